// File: rtl/eth_pkg.sv
// Types and limits shared by the payload framer and the Ethernet transmitter.
package eth_pkg;

  localparam int MAX_PAYLOAD_DEFAULT = 1472;
  localparam int LEN_W = 12;

  typedef logic [LEN_W-1:0] frame_len_t;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } framer_state_t;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/framer_ram.sv
// Frame buffer: simple dual-port RAM with synchronous write and registered read.
module framer_ram #(
  parameter int DEPTH = 1472,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Write-first on a colliding address so a byte written on the closing
  // handshake is already visible on the read port the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

endmodule

// File: rtl/payload_framer.sv
// Store-and-forward framer: buffers user bytes into frames of at most MAX_PAYLOAD
// bytes, then replays each frame with its length on tuser.
//
// state | meaning
// FILL  | accepting user bytes into the buffer, idle timer running
// SEND  | replaying the buffered frame on the m00 side
module payload_framer
  import eth_pkg::*;
#(
  parameter int MAX_PAYLOAD    = MAX_PAYLOAD_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic         s00_axis_aclk,
  input  logic         s00_axis_aresetn,
  input  logic [7:0]   s00_axis_tdata,
  input  logic         s00_axis_tvalid,
  input  logic         s00_axis_tlast,
  output logic         s00_axis_tready,
  output logic [7:0]   m00_axis_tdata,
  output logic         m00_axis_tvalid,
  output logic         m00_axis_tlast,
  output logic [11:0]  m00_axis_tuser,
  input  logic         m00_axis_tready,
  output logic         frame_cut
);

  localparam int            AW          = addr_bits(MAX_PAYLOAD);
  localparam int            TW          = $clog2(TIMEOUT_CYCLES + 2);
  localparam frame_len_t    MAX_LEN     = frame_len_t'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  localparam bit            TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  framer_state_t state, nxt_state;
  frame_len_t    count, nxt_count, rd_ptr, nxt_rd_ptr, len, nxt_len;
  logic [TW-1:0] timer, nxt_timer;
  logic          tlast_q, nxt_tlast, cut_q, nxt_cut, tready_q;
  logic          s_hs, m_hs, at_max, ram_rd_en;
  logic [AW-1:0] ram_rd_addr;

  assign s_hs   = s00_axis_tvalid && tready_q;
  assign m_hs   = (state == SEND) && m00_axis_tready;
  assign at_max = ((count + 1'b1) == MAX_LEN);

  // Read port runs one byte ahead during SEND so the next byte is ready on each handshake.
  assign ram_rd_en   = (state == FILL) || m_hs;
  assign ram_rd_addr = ((state == SEND) && !tlast_q) ? AW'(rd_ptr + 1'b1) : '0;

  framer_ram #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_ram (
    .clk     (s00_axis_aclk),
    .rst_n   (s00_axis_aresetn),
    .wr_en   (s_hs),
    .wr_addr (AW'(count)),
    .wr_data (s00_axis_tdata),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (m00_axis_tdata)
  );

  always_comb begin
    nxt_state  = state;
    nxt_count  = count;
    nxt_rd_ptr = rd_ptr;
    nxt_len    = len;
    nxt_timer  = timer;
    nxt_tlast  = tlast_q;
    nxt_cut    = 1'b0;
    case (state)
      FILL: begin
        if (s_hs) begin
          nxt_timer = '0;
          if (s00_axis_tlast || at_max) begin
            nxt_state  = SEND;
            nxt_len    = count + 1'b1;
            nxt_count  = '0;
            nxt_rd_ptr = '0;
            nxt_tlast  = (count == '0);
            nxt_cut    = !s00_axis_tlast;
          end else begin
            nxt_count = count + 1'b1;
          end
        end else if (count != '0) begin
          if (TIMEOUT_EN && (timer == TIMEOUT_VAL)) begin
            nxt_state  = SEND;
            nxt_len    = count;
            nxt_count  = '0;
            nxt_rd_ptr = '0;
            nxt_timer  = '0;
            nxt_tlast  = (count == frame_len_t'(1));
          end else if (TIMEOUT_EN) begin
            nxt_timer = timer + 1'b1;
          end
        end
      end
      SEND: begin
        if (m_hs) begin
          if (tlast_q) begin
            nxt_state  = FILL;
            nxt_rd_ptr = '0;
            nxt_tlast  = 1'b0;
          end else begin
            nxt_rd_ptr = rd_ptr + 1'b1;
            nxt_tlast  = ((rd_ptr + frame_len_t'(2)) == len);
          end
        end
      end
      default: nxt_state = FILL;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state    <= FILL;
      count    <= '0;
      rd_ptr   <= '0;
      len      <= '0;
      timer    <= '0;
      tlast_q  <= 1'b0;
      cut_q    <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state    <= nxt_state;
      count    <= nxt_count;
      rd_ptr   <= nxt_rd_ptr;
      len      <= nxt_len;
      timer    <= nxt_timer;
      tlast_q  <= nxt_tlast;
      cut_q    <= nxt_cut;
      tready_q <= (nxt_state == FILL);
    end
  end

  assign s00_axis_tready = tready_q;
  assign m00_axis_tvalid = (state == SEND);
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tuser  = len;
  assign frame_cut       = cut_q;

endmodule

// File: tb/tb_payload_framer.sv
// Bench for payload_framer: a negedge monitor scores every output byte and frame
// against a chunking model of the user messages; tasks drive each scenario.
module tb_payload_framer;

  localparam int MAXP       = 1472;
  localparam int TO         = 10;
  localparam int WAIT_LIMIT = 8000;

  typedef logic [7:0] byte_q_t[$];

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic [7:0]  s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast  = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast;
  logic [11:0] m_tuser;
  logic        m_tready = 1'b1;
  logic        frame_cut;

  int checks = 0, errors = 0, cyc = 0;
  int ready_mode = 0;
  int cut_count = 0, frames_seen = 0, first_valid_cyc = -1;
  logic [7:0] exp_data[$];
  int         exp_len[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  payload_framer #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rstn),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (s_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tuser   (m_tuser),
    .m00_axis_tready  (m_tready),
    .frame_cut        (frame_cut)
  );

  // Monitor: p* hold what was presented at the previous posedge.
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b0;
  logic [7:0]  pd = '0, exp_b;
  logic [11:0] pu = '0, cur_user = '0;
  int          cur_len = 0, exp_l;

  always @(negedge clk) begin
    if (prst && pv && !pr) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl || m_tuser !== pu) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%h l=%b u=%0d, required v=1 d=%h l=%b u=%0d",
                 m_tvalid, m_tdata, m_tlast, m_tuser, pd, pl, pu);
      end
    end
    if (!prst) begin
      cur_len = 0;
    end else if (pv && pr) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL out_byte: got unexpected byte %h, required no byte", pd);
      end else begin
        exp_b = exp_data.pop_front();
        if (pd !== exp_b) begin
          errors++;
          $display("FAIL out_byte: got %h, required %h", pd, exp_b);
        end
      end
      if (cur_len == 0) begin
        cur_user = pu;
      end else begin
        checks++;
        if (pu !== cur_user) begin
          errors++;
          $display("FAIL tuser_const: got %0d, required %0d", pu, cur_user);
        end
      end
      cur_len++;
      if (pl) begin
        frames_seen++;
        checks++;
        exp_l = (exp_len.size() != 0) ? exp_len.pop_front() : -1;
        if (cur_len != exp_l || int'(cur_user) != exp_l) begin
          errors++;
          $display("FAIL frame_len: got bytes=%0d tuser=%0d, required %0d", cur_len, cur_user, exp_l);
        end
        cur_len = 0;
      end
    end
    if (prst && frame_cut === 1'b1) cut_count++;
    if (prst && m_tvalid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    pv = m_tvalid; pd = m_tdata; pl = m_tlast; pu = m_tuser;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    pr = m_tready;
    prst = rstn;
  end

  // Reference: a message becomes ceil(L/MAXP) frames; every full chunk not ended by tlast is a cut.
  task automatic model_message(input byte_q_t msg, input bit last, output int nframes, output int ncuts);
    int l = msg.size();
    foreach (msg[i]) exp_data.push_back(msg[i]);
    nframes = (l + MAXP - 1) / MAXP;
    for (int f = 0; f < nframes; f++) exp_len.push_back((f == nframes - 1) ? l - f * MAXP : MAXP);
    ncuts = last ? (l - 1) / MAXP : l / MAXP;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit last, output int hs_cyc);
    bit taken = 1'b0;
    int n = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    while (!taken && n < WAIT_LIMIT) begin
      @(negedge clk);
      taken = (s_tready === 1'b1);
      @(posedge clk); #2;
      n++;
    end
    hs_cyc = cyc;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!taken) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no tready in %0d cycles, required tready", n);
    end
  endtask

  task automatic send_message(input byte_q_t msg, input bit last, input int gap_max, output int last_hs);
    last_hs = 0;
    foreach (msg[i]) begin
      int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin @(posedge clk); #2; end
      push_byte(msg[i], last && (i == msg.size() - 1), last_hs);
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_seen < target && n < WAIT_LIMIT) begin @(negedge clk); n++; end
    @(posedge clk); #2;
  endtask

  function automatic byte_q_t rand_msg(input int l);
    byte_q_t q;
    for (int i = 0; i < l; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", m_tvalid); end
    if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, required 0", m_tlast); end
    if (m_tuser !== 12'd0) begin errors++; $display("FAIL rst_tuser: got %0d, required 0", m_tuser); end
    if (m_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h, required 00", m_tdata); end
    if (frame_cut !== 1'b0) begin errors++; $display("FAIL rst_cut: got %b, required 0", frame_cut); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, required 0", s_tready); end
    @(posedge clk); #2;
    s_tvalid = 1'b0; s_tlast = 1'b0; rstn = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b, required 1", s_tready); end
    @(posedge clk); #2;
  endtask

  task automatic test_basic();
    byte_q_t msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int nf, nc, hs, f0 = frames_seen, c0 = cut_count;
    ready_mode = 0;
    model_message(msg, 1'b1, nf, nc);
    first_valid_cyc = -1;
    send_message(msg, 1'b1, 0, hs);
    wait_frames(f0 + nf);
    checks += 3;
    if (frames_seen - f0 != nf) begin errors++; $display("FAIL basic_frames: got %0d, required %0d", frames_seen - f0, nf); end
    if (cut_count - c0 != nc) begin errors++; $display("FAIL basic_cut: got %0d, required %0d", cut_count - c0, nc); end
    if (first_valid_cyc - hs < 0 || first_valid_cyc - hs > 2) begin
      errors++; $display("FAIL basic_latency: got %0d cycles, required 0..2", first_valid_cyc - hs);
    end
  endtask

  task automatic test_cut_timeout();
    byte_q_t msg = rand_msg(1500);
    int nf, nc, hs, f0 = frames_seen, c0 = cut_count;
    ready_mode = 0;
    model_message(msg, 1'b0, nf, nc);
    send_message(msg, 1'b0, 0, hs);
    wait_frames(f0 + nf);
    checks += 2;
    if (frames_seen - f0 != nf) begin errors++; $display("FAIL cut_frames: got %0d, required %0d", frames_seen - f0, nf); end
    if (cut_count - c0 != nc) begin errors++; $display("FAIL cut_pulses: got %0d, required %0d", cut_count - c0, nc); end
  endtask

  task automatic test_timeout_latency();
    byte_q_t msg = rand_msg(3);
    int nf, nc, hs, f0 = frames_seen, c0 = cut_count;
    ready_mode = 0;
    model_message(msg, 1'b0, nf, nc);
    first_valid_cyc = -1;
    send_message(msg, 1'b0, 0, hs);
    wait_frames(f0 + nf);
    checks += 3;
    if (frames_seen - f0 != nf) begin errors++; $display("FAIL idle_frames: got %0d, required %0d", frames_seen - f0, nf); end
    if (cut_count - c0 != nc) begin errors++; $display("FAIL idle_cut: got %0d, required %0d", cut_count - c0, nc); end
    if (first_valid_cyc - hs < TO || first_valid_cyc - hs > TO + 2) begin
      errors++; $display("FAIL idle_latency: got %0d cycles, required %0d..%0d", first_valid_cyc - hs, TO, TO + 2);
    end
  endtask

  task automatic test_backpressure();
    byte_q_t msg = rand_msg(10);
    int nf, nc, hs, n = 0, f0 = frames_seen;
    ready_mode = 1;
    model_message(msg, 1'b1, nf, nc);
    send_message(msg, 1'b1, 0, hs);
    while (frames_seen < f0 + nf && n < WAIT_LIMIT) begin
      @(negedge clk); n++;
      if (m_tvalid === 1'b1) begin
        checks++;
        if (s_tready !== 1'b0) begin errors++; $display("FAIL send_tready: got %b, required 0", s_tready); end
      end
    end
    checks += 2;
    if (frames_seen - f0 != nf) begin errors++; $display("FAIL bp_frames: got %0d, required %0d", frames_seen - f0, nf); end
    if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_return_tready: got %b, required 1", s_tready); end
    @(posedge clk); #2;
    ready_mode = 0;
  endtask

  task automatic test_reset_midframe();
    byte_q_t msg = rand_msg(8), msg2 = rand_msg(2);
    int nf, nc, hs, n = 0, f0;
    ready_mode = 0;
    model_message(msg, 1'b1, nf, nc);
    send_message(msg, 1'b1, 0, hs);
    while (cur_len < 4 && n < WAIT_LIMIT) begin @(negedge clk); n++; end
    @(posedge clk); #2;
    rstn = 1'b0;
    @(posedge clk); @(negedge clk);
    checks += 3;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b, required 0", m_tvalid); end
    if (m_tuser !== 12'd0) begin errors++; $display("FAIL midrst_tuser: got %0d, required 0", m_tuser); end
    if (s_tready !== 1'b0) begin errors++; $display("FAIL midrst_tready: got %b, required 0", s_tready); end
    exp_data.delete(); exp_len.delete();
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #2;
    f0 = frames_seen;
    model_message(msg2, 1'b1, nf, nc);
    send_message(msg2, 1'b1, 0, hs);
    wait_frames(f0 + nf);
    checks++;
    if (frames_seen - f0 != nf) begin errors++; $display("FAIL midrst_frames: got %0d, required %0d", frames_seen - f0, nf); end
  endtask

  task automatic test_random();
    int nf, nc, hs, tot_f = 0, tot_c = 0, f0 = frames_seen, c0 = cut_count;
    ready_mode = 2;
    for (int m = 0; m < 14; m++) begin
      byte_q_t msg;
      if (m == 3) msg = rand_msg(MAXP);
      else if (m == 5 || m == 6) msg = rand_msg(1);
      else msg = rand_msg(int'($urandom_range(1, 40)));
      model_message(msg, 1'b1, nf, nc);
      tot_f += nf; tot_c += nc;
      send_message(msg, 1'b1, 3, hs);
    end
    wait_frames(f0 + tot_f);
    checks += 3;
    if (frames_seen - f0 != tot_f) begin errors++; $display("FAIL rand_frames: got %0d, required %0d", frames_seen - f0, tot_f); end
    if (cut_count - c0 != tot_c) begin errors++; $display("FAIL rand_cut: got %0d, required %0d", cut_count - c0, tot_c); end
    if (exp_data.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d bytes unsent, required 0", exp_data.size()); end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cut_timeout();
    test_timeout_latency();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
